// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, burst-granting arbiter for the single FIFO
// write port. One producer owns the port for up to MAX_BURST words per grant,
// and every burst is followed by one IDLE cycle.
// Optional feature macro: FWA_STALL_CNT_EN enables the full-stall counter.
module fifo_write_arbiter #(
  parameter int N_REQ      = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*FIFO_WIDTH-1:0]   din,
  input  logic                          full,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              ack,
  output logic                          wen_a,
  output logic [FIFO_WIDTH-1:0]         din_a,
  output logic [15:0]                   stall_cnt
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e                 state_q, state_d;
  logic [N_REQ-1:0]       gnt_q, gnt_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          last_q, last_d;
  logic [BW-1:0]          bcnt_q, bcnt_d;

  logic [N_REQ-1:0][FIFO_WIDTH-1:0] din_v;
  logic                   in_grant;
  logic                   req_g;
  logic                   wen;
  logic                   last_word;
  logic                   rr_found;
  logic [IW-1:0]          rr_idx;

  assign din_v     = din;
  assign in_grant  = (state_q == S_GRANT);
  assign req_g     = req[gidx_q];
  assign wen       = in_grant & req_g & ~full;
  assign last_word = (bcnt_q == BW'(MAX_BURST - 1));

  // Write-side outputs are combinational from the held grant and live req/full.
  assign gnt   = gnt_q;
  assign wen_a = wen;
  assign ack   = wen ? gnt_q : '0;
  assign din_a = in_grant ? din_v[gidx_q] : '0;

  // Round-robin pick: first requester above the last owner, wrapping.
  always_comb begin : rr_pick
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_q) + k) % N_REQ;
      if (!rr_found && req[idx]) begin
        rr_found = 1'b1;
        rr_idx   = IW'(idx);
      end
    end
  end

  // Next-state: grant on any request in IDLE, release on req drop or burst end.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          state_d = S_GRANT;
          gidx_d  = rr_idx;
          gnt_d   = N_REQ'(1) << rr_idx;
          bcnt_d  = '0;
        end
      end
      S_GRANT: begin
        // A final-word write with req low is still just one exit.
        if (!req_g || (wen && last_word)) begin
          state_d = S_IDLE;
          last_d  = gidx_q;
          gnt_d   = '0;
          bcnt_d  = '0;
        end else if (wen) begin
          bcnt_d  = bcnt_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Arbiter state registers; pointer resets so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(N_REQ - 1);
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

`ifdef FWA_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Count cycles where the owner wants to write but the FIFO is full; saturate.
  always_comb begin
    stall_d = stall_q;
    if (in_grant && req_g && full && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: default instance (N_REQ=4, burst 8)
// plus a MAX_BURST=1 instance sharing clock and reset.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
`ifdef FWA_STALL_CNT_EN
  localparam logic [15:0] EXP_STALL = 16'd5;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, req1;
  logic [N*W-1:0] din;
  logic           full;
  logic [N-1:0]   gnt, ack, gnt1, ack1;
  logic           wen_a, wen1;
  logic [W-1:0]   din_a, dina1;
  logic [15:0]    stall_cnt, stall1;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] slice [N];

  always #5 clk = ~clk;

  fifo_write_arbiter #(.N_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .full(full),
    .gnt(gnt), .ack(ack), .wen_a(wen_a), .din_a(din_a), .stall_cnt(stall_cnt)
  );

  fifo_write_arbiter #(.N_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .din(din), .full(full),
    .gnt(gnt1), .ack(ack1), .wen_a(wen1), .din_a(dina1), .stall_cnt(stall1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at a negedge with reset just released, state IDLE.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; req1 = '0; full = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    slice[0] = 16'hA0A0; slice[1] = 16'hB1B1; slice[2] = 16'hC2C2; slice[3] = 16'hD3D3;
    din   = {slice[3], slice[2], slice[1], slice[0]};
    rst_n = 1'b0; req = '0; req1 = '0; full = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_wen", 32'(wen_a), 0);
    chk("rst_din_a", 32'(din_a), 0);
    chk("rst_stall", 32'(stall_cnt), 0);

    // Single requester 0: 8 acks, one idle cycle, re-grant
    do_reset();
    req = 4'b0001;
    #1 chk("t1_idle0", 32'(gnt), 0);
    for (int w = 0; w < 8; w++) begin
      @(negedge clk); #1;
      chk("t1_gnt", 32'(gnt), 32'h1);
      chk("t1_ack", 32'(ack), 32'h1);
    end
    @(negedge clk); #1;
    chk("t1_gap_gnt", 32'(gnt), 0);
    chk("t1_gap_wen", 32'(wen_a), 0);
    chk("t1_gap_din_a", 32'(din_a), 0);
    @(negedge clk); #1;
    chk("t1_regnt", 32'(gnt), 32'h1);

    // All requesting: order 0,1,2,3,0 with 8 writes each
    do_reset();
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      for (int w = 0; w < 8; w++) begin
        @(negedge clk); #1;
        chk("t2_gnt", 32'(gnt), 32'(1 << (b % 4)));
        chk("t2_ack", 32'(ack), 32'(1 << (b % 4)));
        chk("t2_din_a", 32'(din_a), 32'(slice[b % 4]));
      end
      @(negedge clk); #1;
      chk("t2_gap", 32'(gnt), 0);
    end

    // Requester 2 with a 5-cycle full stall after 3 writes
    do_reset();
    req = 4'b0100;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk); #1;
      chk("t3_ack_pre", 32'(ack), 32'h4);
      chk("t3_din_a", 32'(din_a), 32'(slice[2]));
    end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk); full = 1'b1; #1;
      chk("t3_stall_wen", 32'(wen_a), 0);
      chk("t3_stall_ack", 32'(ack), 0);
      chk("t3_stall_gnt", 32'(gnt), 32'h4);
    end
    @(negedge clk); full = 1'b0; #1;
    chk("t3_stall_cnt", 32'(stall_cnt), 32'(EXP_STALL));
    chk("t3_ack_post", 32'(ack), 32'h4);
    for (int w = 0; w < 4; w++) begin
      @(negedge clk); #1;
      chk("t3_ack_post", 32'(ack), 32'h4);
    end
    @(negedge clk); #1;
    chk("t3_end_gnt", 32'(gnt), 0);
    chk("t3_stall_hold", 32'(stall_cnt), 32'(EXP_STALL));

    // Requester 1 drops after 2 writes; next search starts at 2
    do_reset();
    req = 4'b0010;
    #1 chk("t4_idle", 32'(gnt), 0);
    @(negedge clk); req = 4'b0011; #1;
    chk("t4_gnt", 32'(gnt), 32'h2);
    chk("t4_ack1", 32'(ack), 32'h2);
    @(negedge clk); #1;
    chk("t4_ack2", 32'(ack), 32'h2);
    chk("t4_din_a", 32'(din_a), 32'(slice[1]));
    @(negedge clk); req = 4'b1101; #1;
    chk("t4_drop_gnt", 32'(gnt), 32'h2);
    chk("t4_drop_ack", 32'(ack), 0);
    chk("t4_drop_wen", 32'(wen_a), 0);
    @(negedge clk); #1;
    chk("t4_idle_after", 32'(gnt), 0);
    @(negedge clk); #1;
    chk("t4_rr_next", 32'(gnt), 32'h4);

    // Reset mid-burst, then pointer restarts
    do_reset();
    req = 4'b0001;
    for (int w = 0; w < 3; w++) @(negedge clk);
    #1 chk("t5_mid", 32'(gnt), 32'h1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); #1;
    chk("t5_rst_gnt", 32'(gnt), 0);
    chk("t5_rst_ack", 32'(ack), 0);
    chk("t5_rst_wen", 32'(wen_a), 0);
    chk("t5_rst_din_a", 32'(din_a), 0);
    chk("t5_rst_stall", 32'(stall_cnt), 0);
    rst_n = 1'b1; req = 4'b1000;
    @(negedge clk); #1;
    chk("t5_gnt3", 32'(gnt), 32'h8);
    chk("t5_din3", 32'(din_a), 32'(slice[3]));
    do_reset();
    req = 4'b1001;
    @(negedge clk); #1;
    chk("t5_gnt0", 32'(gnt), 32'h1);

    // MAX_BURST=1: alternating single-word grants with idle between
    do_reset();
    req1 = 4'b0011;
    begin
      logic [3:0] exp_seq [7];
      exp_seq = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h1, 4'h0, 4'h2};
      for (int i = 0; i < 7; i++) begin
        @(negedge clk); #1;
        chk("t6_gnt", 32'(gnt1), 32'(exp_seq[i]));
        chk("t6_ack", 32'(ack1), 32'(exp_seq[i]));
      end
    end
    chk("t6_din_a", 32'(dina1), 32'(slice[1]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

- Round-robin, burst-granting arbiter that shares the single write port of the team's FIFO memory among `N_REQ` producers in the write-clock domain.
- Each producer requests, receives a grant for a burst of up to `MAX_BURST` words, and sees a per-word acknowledge.
- The arbiter drives the FIFO's `wen_a`/`din_a` and obeys its `full` flag.
- Sits directly in front of the FIFO write side, in the `clk_a` domain.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `FIFO_WIDTH`, default 16: data word width; matches the FIFO.
- `MAX_BURST`, default 8: maximum words written per grant, 1..255.
- `clk`, input, 1: write-domain clock (connects to FIFO `clk_a`).
- `rst_n`, input, 1: reset, synchronous, active-low.
- `req`, input, `N_REQ`: per-requester request; held high while the requester has data.
- `din`, input, `N_REQ*FIFO_WIDTH`: packed requester data; requester i occupies bits `[i*FIFO_WIDTH +: FIFO_WIDTH]`.
- `full`, input, 1: FIFO full flag.
- `gnt`, output, `N_REQ`: registered one-hot grant; all-zero when no grant.
- `ack`, output, `N_REQ`: one-hot; high in the cycle the granted requester's word is written.
- `wen_a`, output, 1: FIFO write enable.
- `din_a`, output, `FIFO_WIDTH`: FIFO write data.
- `stall_cnt`, output, 16: saturating full-stall counter (see Configuration).

## Operation
- Two states.
  - IDLE: `gnt` = 0.
  - GRANT: `gnt` one-hot at index g.
- **IDLE:**
  - If `req` is nonzero, pick the winner by round-robin: search from `(last+1) mod N_REQ` upward, wrapping.
  - Load `gnt`, set burst count to 0, go to GRANT.
  - If `req` is zero, stay in IDLE.
- **GRANT, combinational each cycle:**
  - `wen_a = req[g] & ~full`.
  - `din_a` = slice g of `din`.
  - `ack[g] = wen_a`; all other `ack` bits are 0.
- **GRANT, registered:**
  - Each write increments the burst count (width `$clog2(MAX_BURST+1)`).
  - Exit to IDLE when either:
    - `req[g]` is 0, or
    - a write occurs with burst count equal to `MAX_BURST-1`.
  - On exit: `last <= g`, `gnt <= 0`.
- **full:**
  - While `full`=1 in GRANT: no write, burst count frozen, grant held indefinitely.
  - If `req[g]` drops while full, the grant is released normally.
- `wen_a` is never high outside GRANT, and never high while `full`=1.
- `din_a` = 0 when `gnt` = 0.
- Requests from non-granted requesters are ignored until the next IDLE cycle.

## Timing
- Reset values: `gnt`=0, `ack`=0, `wen_a`=0, `din_a`=0, `stall_cnt`=0, state IDLE, burst count 0.
- Round-robin pointer `last` resets to `N_REQ-1`, so requester 0 wins the first arbitration.
- Latency: `req` seen high at edge t in IDLE → `gnt` high after edge t; first write possible in the same cycle.
- Every burst end costs exactly one IDLE cycle (`gnt`=0) before the next grant.
- Max throughput: `MAX_BURST` words per `MAX_BURST+1` cycles.
- Burst of 1 (`MAX_BURST`=1): GRANT lasts one write, then IDLE.
- Simultaneous exit conditions (write of the final burst word and `req` low): a single exit, no extra cycle.
- `rst_n` low mid-burst: all state clears at that edge and the partial burst is abandoned. Words already acked are in the FIFO; no rollback.
- `full` and `req` are sampled combinationally for `wen_a`. There are no registered paths from `din` to `din_a`.

## Configuration
- `FWA_STALL_CNT_EN` defined:
  - `stall_cnt` increments on each cycle with GRANT, `req[g]`=1 and `full`=1.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- `FWA_STALL_CNT_EN` undefined:
  - No counter logic.
  - `stall_cnt` is tied to 0.
  - The port remains so the port list is stable.

## Test plan
- Reset, then `req`=4'b0001, `full`=0 held → `gnt`=0001 next cycle; 8 acks on consecutive cycles; `gnt`=0 for 1 cycle; then re-grant to requester 0.
- `req`=4'b1111 held, `full`=0 → grant order 0,1,2,3,0 with 8 writes each and one idle cycle between bursts; `din_a` carries the correct slice each time.
- Requester 2 granted, `full`=1 for 5 cycles after 3 writes:
  - `wen_a`=0 and `ack`=0 during the stall; grant held.
  - Remaining 5 writes follow the stall.
  - `stall_cnt`=5 with the macro, 0 without.
- `req[1]` drops after 2 writes → release on that cycle, IDLE next cycle, next grant search starts at requester 2.
- `rst_n`=0 in the middle of a burst → all outputs 0 after the edge; after release, `req`=4'b1000 grants requester 3 and `req`=4'b1001 grants requester 0 (pointer reset).
- `MAX_BURST`=1, `req`=4'b0011 → alternating single-word grants 0,1,0,1 with an idle cycle between each.
